// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter feeding the register file write port.
// One-entry writeback stage doubles as the operand bypass.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned XLEN         = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    output logic            rf_write_enable,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_write_data,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            b_boosted
);

    typedef enum logic {
        NORMAL,
        BOOST_B
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t          state;
    state_t          state_nx;
    logic [3:0]      starve_cnt;
    logic [3:0]      cnt_nx;
    logic            a_fire;
    logic            b_fire;
    logic            g_fire;
    logic [4:0]      g_rd;
    logic [XLEN-1:0] g_data;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            unique case (state)
                NORMAL: begin
                    a_ready = a_valid;
                    b_ready = b_valid && !a_valid;
                end
                BOOST_B: begin
                    b_ready = b_valid;
                    a_ready = a_valid && !b_valid;
                end
                default: begin
                    a_ready = 1'b0;
                    b_ready = 1'b0;
                end
            endcase
        end
    end

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;
    assign g_fire = a_fire || b_fire;
    assign g_rd   = b_fire ? b_rd : a_rd;
    assign g_data = b_fire ? b_data : a_data;

    // Boost is entered on the same edge the counter reaches the limit.
    always_comb begin
        cnt_nx   = starve_cnt;
        state_nx = state;
        if (b_fire) begin
            cnt_nx   = 4'd0;
            state_nx = NORMAL;
        end else if (b_valid && starve_cnt < LIMIT) begin
            cnt_nx = starve_cnt + 4'd1;
        end
        if (!b_fire && state == NORMAL && cnt_nx == LIMIT) begin
            state_nx = BOOST_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nx;
            starve_cnt <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_enable <= 1'b0;
            rf_rd           <= 5'd0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= g_fire && (g_rd != 5'd0);
            if (g_fire) begin
                rf_rd         <= g_rd;
                rf_write_data <= g_data;
            end
        end
    end

    assign fwd_valid = rf_write_enable;
    assign fwd_rd    = rf_rd;
    assign fwd_data  = rf_write_data;
    assign b_boosted = (state == BOOST_B);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: reference arbitration
// model, directed scenarios, then constrained random traffic.
module tb_regfile_wb_arbiter;

    localparam int LIM  = 4;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            a_ready;
    logic            b_valid;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            b_ready;
    logic            rf_write_enable;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_write_data;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            b_boosted;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIM), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rf_write_enable(rf_write_enable), .rf_rd(rf_rd),
        .rf_write_data(rf_write_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .b_boosted(b_boosted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [68:0] sb[$];
    logic        m_boost;
    int          m_cnt;
    int          b_wait;
    logic        last_a_grant;
    logic        last_b_grant;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: inputs are already driven just after the previous edge.
    task automatic tick();
        logic ea, eb, ga, gb, ewe;
        logic [68:0] ent;
        #1;
        ea = !rst && a_valid && (!m_boost || !b_valid);
        eb = !rst && b_valid && (m_boost || !a_valid);
        check("a_ready", 64'(a_ready), 64'(ea));
        check("b_ready", 64'(b_ready), 64'(eb));
        ga = ea && !eb;
        gb = eb;
        last_a_grant = ga;
        last_b_grant = gb;
        ewe = 1'b0;
        if (gb && b_rd != 0) begin
            sb.push_back({b_rd, b_data});
            ewe = 1'b1;
        end else if (ga && a_rd != 0) begin
            sb.push_back({a_rd, a_data});
            ewe = 1'b1;
        end
        if (b_valid && !rst) begin
            b_wait++;
            if (gb) begin
                check("b_wait_bound", 64'(b_wait <= LIM + 1), 64'd1);
                b_wait = 0;
            end
        end
        @(posedge clk);
        if (rst) begin
            m_boost = 1'b0;
            m_cnt   = 0;
            b_wait  = 0;
        end else if (gb) begin
            m_boost = 1'b0;
            m_cnt   = 0;
        end else if (b_valid) begin
            if (m_cnt < LIM) m_cnt++;
            if (m_cnt == LIM) m_boost = 1'b1;
        end
        #1;
        check("rf_we", 64'(rf_write_enable), 64'(ewe));
        check("b_boosted", 64'(b_boosted), 64'(m_boost));
        check("fwd_eq", 64'({fwd_valid, fwd_rd} == {rf_write_enable, rf_rd}
                            && fwd_data == rf_write_data), 64'd1);
        if (rst) begin
            check("rst_rd", 64'(rf_rd), 64'd0);
            check("rst_data", rf_write_data, 64'd0);
        end
        if (rf_write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_empty", 64'd1, 64'd0);
            end else begin
                ent = sb.pop_front();
                check("wb_rd", 64'(rf_rd), 64'(ent[68:64]));
                check("wb_data", rf_write_data, ent[63:0]);
            end
        end
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        logic        ap, bp;
        int          k;
        m_boost = 1'b0;
        m_cnt   = 0;
        b_wait  = 0;
        rst = 1'b1;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        tick();
        tick();
        check("reset_boost", 64'(b_boosted), 64'd0);
        rst = 1'b0;
        tick();

        // Single A write
        a_valid = 1'b1; a_rd = 5'd5; a_data = 64'hDEAD_BEEF;
        tick();
        check("t1_rd", 64'(rf_rd), 64'd5);
        check("t1_data", rf_write_data, 64'hDEAD_BEEF);
        check("t1_fwd", 64'(fwd_valid), 64'd1);
        idle();
        tick();
        check("t1_we_off", 64'(rf_write_enable), 64'd0);

        // A and B together: A first, then B
        a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h33;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 64'h77;
        tick();
        check("t2_first", 64'(rf_rd), 64'd3);
        a_valid = 1'b0;
        tick();
        check("t2_second", 64'(rf_rd), 64'd7);
        check("t2_noboost", 64'(b_boosted), 64'd0);
        idle();
        tick();

        // Starvation: A every cycle, B held
        b_valid = 1'b1; b_rd = 5'd9; b_data = 64'h99;
        k = 0;
        for (int i = 1; i <= 3 * LIM; i++) begin
            a_valid = 1'b1; a_rd = 5'(10 + (i % 8)); a_data = 64'(i);
            tick();
            if (last_b_grant) begin
                k = i;
                check("t3_a_blocked", 64'(last_a_grant), 64'd0);
                check("t3_rd9", 64'(rf_rd), 64'd9);
                break;
            end
        end
        check("t3_grant_cycle", 64'(k), 64'(LIM + 1));
        b_valid = 1'b0;
        tick();
        check("t3_normal", 64'(b_boosted), 64'd0);
        idle();
        tick();

        // rd=0 consumed, no write
        a_valid = 1'b1; a_rd = 5'd0; a_data = 64'h1234;
        tick();
        check("t4_a_acc", 64'(last_a_grant), 64'd1);
        check("t4_fwd_off", 64'(fwd_valid), 64'd0);
        a_valid = 1'b0;
        b_valid = 1'b1; b_rd = 5'd2; b_data = 64'h2222;
        tick();
        check("t4_b_rd", 64'(rf_rd), 64'd2);
        idle();
        tick();

        // Reset right after an A grant, B held across it
        a_valid = 1'b1; a_rd = 5'd4; a_data = 64'h4444;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1; b_rd = 5'd6; b_data = 64'h6666;
        rst = 1'b1;
        tick();
        check("t5_we", 64'(rf_write_enable), 64'd0);
        rst = 1'b0;
        tick();
        check("t5_b_after", 64'(rf_rd), 64'd6);
        idle();
        tick();

        // Random traffic with hold-until-accepted sources
        ap = 1'b0; bp = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!ap && $urandom_range(99) < 60) begin
                ap = 1'b1;
                a_rd = 5'($urandom_range(31));
                a_data = {$urandom, $urandom};
                if (bp && a_rd == b_rd) a_rd = a_rd + 5'd1;
            end
            if (!bp && $urandom_range(99) < 40) begin
                bp = 1'b1;
                b_rd = 5'($urandom_range(31));
                b_data = {$urandom, $urandom};
                if (ap && b_rd == a_rd) b_rd = b_rd + 5'd1;
            end
            a_valid = ap;
            b_valid = bp;
            tick();
            if (last_a_grant) ap = 1'b0;
            if (last_b_grant) bp = 1'b0;
        end
        idle();
        tick();
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
